bram_fifo: RTL and testbench

Parametrised single-clock FIFO built on an inferred block-RAM array, succeeding the fixed 256x16 dual-port bram.
- Adds a valid/ready stream interface on both sides, occupancy tracking, full/empty flow control and first-word-fall-through output.
- Sits between producers and consumers (UART/serial, SPI, LED pattern engines) wherever more than a few words of elastic buffering are needed.

---
 rtl/bram_fifo_if.sv | 41 ++++
 rtl/bram_fifo.sv | 87 ++++++++
 tb/tb_bram_fifo.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_fifo_if.sv
// ---------------------------------------------------------------------------
// bram_fifo_if -- stream handshake bundle for bram_fifo.
//   Write side : i_data, i_valid (producer -> FIFO), o_ready (FIFO -> producer)
//   Read side  : o_data, o_valid (FIFO -> consumer), i_ready (consumer -> FIFO)
//   o_count    : occupancy, only when FIFO_COUNT_EN is defined
// Modports: slave = FIFO side, master = producer/consumer side.
// Signal names are from the FIFO's point of view.
// Optional macro: FIFO_COUNT_EN (adds ADDR_WIDTH parameter and o_count).
// ---------------------------------------------------------------------------
interface bram_fifo_if #(
    parameter int DATA_WIDTH = 16
`ifdef FIFO_COUNT_EN
    , parameter int ADDR_WIDTH = 8
`endif
);
    logic [DATA_WIDTH-1:0] i_data;
    logic                  i_valid;
    logic                  o_ready;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_valid;
    logic                  i_ready;
`ifdef FIFO_COUNT_EN
    logic [ADDR_WIDTH:0]   o_count;
`endif

    modport slave (
        input  i_data, i_valid, i_ready,
`ifdef FIFO_COUNT_EN
        output o_count,
`endif
        output o_ready, o_data, o_valid
    );

    modport master (
        output i_data, i_valid, i_ready,
`ifdef FIFO_COUNT_EN
        input  o_count,
`endif
        input  o_ready, o_data, o_valid
    );
endinterface

// File: rtl/bram_fifo.sv
// ---------------------------------------------------------------------------
// bram_fifo -- single-clock first-word-fall-through FIFO on an inferred BRAM.
//   i_clk   : clock for all logic and memory
//   i_rst_n : asynchronous active-low reset (memory contents not cleared)
//   bus     : bram_fifo_if.slave -- valid/ready write and read streams,
//             plus o_count occupancy when FIFO_COUNT_EN is defined
// Read path: BRAM read register (mem_q / mem_v) -> output register
// (o_data / o_valid), giving 2 cycles from push to o_valid.
// Optional macro: FIFO_COUNT_EN exposes the internal occupancy count.
// ---------------------------------------------------------------------------
module bram_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    bram_fifo_if.slave bus
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] mem_q;
    logic [DATA_WIDTH-1:0] out_d;
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]         count, count_next, unread;
    logic                  mem_v, out_v, rdy;
    logic                  push, pop, load_out, rd_issue;

    assign push     = bus.i_valid & rdy;
    assign pop      = out_v & bus.i_ready;
    assign load_out = ~out_v | pop;
    // Words sitting in the array that have not been handed to the read stage.
    assign unread   = count - CW'(mem_v) - CW'(out_v);
    // Read only when the memory stage is empty or is moving on this edge.
    assign rd_issue = (unread != '0) & (~mem_v | load_out);

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Kept free of reset so the array and its read register map onto BRAM.
    // A slot is only read on an edge after the one that wrote it, since
    // unread counts a word only once its write edge has passed.
    always_ff @(posedge i_clk) begin
        if (push)     mem[wr_ptr] <= bus.i_data;
        if (rd_issue) mem_q       <= mem[rd_ptr];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdy    <= 1'b0;
            mem_v  <= 1'b0;
            out_v  <= 1'b0;
            out_d  <= '0;
        end else begin
            count <= count_next;
            // Registered ready: a pop only frees space from the next cycle.
            rdy   <= (count_next < FULL_CNT);
            if (push)     wr_ptr <= wr_ptr + 1'b1;
            if (rd_issue) rd_ptr <= rd_ptr + 1'b1;

            if (rd_issue)      mem_v <= 1'b1;
            else if (load_out) mem_v <= 1'b0;

            if (load_out) begin
                out_v <= mem_v;
                if (mem_v) out_d <= mem_q;
            end
        end
    end

    assign bus.o_ready = rdy;
    assign bus.o_valid = out_v;
    assign bus.o_data  = out_d;
`ifdef FIFO_COUNT_EN
    assign bus.o_count = count;
`endif
endmodule

// File: tb/tb_bram_fifo.sv
// ---------------------------------------------------------------------------
// tb_bram_fifo -- directed self-checking bench for bram_fifo (256 x 16).
// Occupancy checks are compiled in only when FIFO_COUNT_EN is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bram_fifo;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

`ifdef FIFO_COUNT_EN
    bram_fifo_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) bus ();
`else
    bram_fifo_if #(.DATA_WIDTH(16)) bus ();
`endif

    bram_fifo #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_valid = 1'b0; bus.i_ready = 1'b0; bus.i_data = '0;
        repeat (3) tick();
        n_cmp++;
        if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b0 || bus.o_data !== 16'h0000) begin
            n_err++;
            $display("FAIL in_reset: valid=%b ready=%b data=%h, want 0 0 0000",
                     bus.o_valid, bus.o_ready, bus.o_data);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL after_reset: ready=%b valid=%b, want 1 0", bus.o_ready, bus.o_valid);
        end
`ifdef FIFO_COUNT_EN
        n_cmp++;
        if (bus.o_count !== 9'd0) begin
            n_err++;
            $display("FAIL reset_count: got %0d want 0", bus.o_count);
        end
`endif
    endtask

    task automatic test_latency();
        bus.i_ready = 1'b1;
        bus.i_valid = 1'b1; bus.i_data = 16'h0005;
        tick();                       // E0: push
        bus.i_valid = 1'b0;
        n_cmp++;
        if (bus.o_valid !== 1'b0) begin
            n_err++; $display("FAIL lat_e0: valid=%b want 0", bus.o_valid);
        end
        tick();                       // E1: memory read
        n_cmp++;
        if (bus.o_valid !== 1'b0) begin
            n_err++; $display("FAIL lat_e1: valid=%b want 0", bus.o_valid);
        end
        tick();                       // E2: output register
        n_cmp++;
        if (bus.o_valid !== 1'b1 || bus.o_data !== 16'h0005) begin
            n_err++;
            $display("FAIL lat_e2: valid=%b data=%h want 1 0005", bus.o_valid, bus.o_data);
        end
        tick();                       // E3: popped
        n_cmp++;
        if (bus.o_valid !== 1'b0) begin
            n_err++; $display("FAIL lat_e3: valid=%b want 0", bus.o_valid);
        end
`ifdef FIFO_COUNT_EN
        n_cmp++;
        if (bus.o_count !== 9'd0) begin
            n_err++; $display("FAIL lat_count: got %0d want 0", bus.o_count);
        end
`endif
        bus.i_ready = 1'b0;
    endtask

    // Fill to 256, offer a 257th, then pop-with-push while full, then drain.
    task automatic test_fill_full();
        int stalls = 0;
        int wt;
        logic [15:0] exp;
        bus.i_ready = 1'b0;
        for (int k = 0; k < 256; k++) begin
            if (bus.o_ready !== 1'b1) stalls++;
            bus.i_valid = 1'b1; bus.i_data = 16'(k);
            tick();
        end
        n_cmp++;
        if (stalls != 0) begin
            n_err++; $display("FAIL fill_stalls: got %0d want 0", stalls);
        end
        n_cmp++;
        if (bus.o_ready !== 1'b0) begin
            n_err++; $display("FAIL full_ready: got %b want 0", bus.o_ready);
        end
`ifdef FIFO_COUNT_EN
        n_cmp++;
        if (bus.o_count !== 9'd256) begin
            n_err++; $display("FAIL full_count: got %0d want 256", bus.o_count);
        end
`endif
        bus.i_data = 16'hDEAD;        // 257th offer, must be refused
        tick();
        n_cmp++;
        if (bus.o_ready !== 1'b0 || bus.o_valid !== 1'b1 || bus.o_data !== 16'h0000) begin
            n_err++;
            $display("FAIL full_hold: ready=%b valid=%b data=%h want 0 1 0000",
                     bus.o_ready, bus.o_valid, bus.o_data);
        end
        bus.i_data = 16'hBEEF; bus.i_ready = 1'b1;   // push+pop while full
        tick();
        bus.i_valid = 1'b0; bus.i_ready = 1'b0;
        n_cmp++;
        if (bus.o_ready !== 1'b1 || bus.o_data !== 16'h0001) begin
            n_err++;
            $display("FAIL full_pop: ready=%b data=%h want 1 0001", bus.o_ready, bus.o_data);
        end
`ifdef FIFO_COUNT_EN
        n_cmp++;
        if (bus.o_count !== 9'd255) begin
            n_err++; $display("FAIL full_pop_count: got %0d want 255", bus.o_count);
        end
`endif
        bus.i_ready = 1'b1;
        for (int k = 1; k < 256; k++) begin
            exp = 16'(k);
            wt = 0;
            while (bus.o_valid !== 1'b1 && wt < 8) begin tick(); wt++; end
            n_cmp++;
            if (bus.o_valid !== 1'b1 || bus.o_data !== exp) begin
                n_err++;
                $display("FAIL drain[%0d]: valid=%b data=%h want 1 %h", k, bus.o_valid, bus.o_data, exp);
            end
            tick();
        end
        n_cmp++;
        if (bus.o_valid !== 1'b0) begin
            n_err++; $display("FAIL drain_empty: valid=%b data=%h want 0", bus.o_valid, bus.o_data);
        end
        bus.i_ready = 1'b0;
    endtask

    // Continuous push/pop of n*13+5; data n moves through 4 edges, so
    // steady-state occupancy is 3 words.
    task automatic test_back_to_back();
        int tx = 0, rx = 0, gaps = 0, cyc = 0, rdy_drop = 0, cnt_hi = 0;
        bit seen = 0;
        bit acc, got;
        logic [15:0] exp;
        bus.i_ready = 1'b1;
        while (rx < 1000 && cyc < 1200) begin
            bus.i_valid = (tx < 1000);
            bus.i_data  = 16'(tx * 13 + 5);
            acc = bus.i_valid && bus.o_ready;
            got = (bus.o_valid === 1'b1);
            if (bus.i_valid && bus.o_ready !== 1'b1 && tx > 0) rdy_drop++;
`ifdef FIFO_COUNT_EN
            if (bus.o_count > 9'd3) cnt_hi++;
`endif
            if (got) begin
                seen = 1;
                exp = 16'(rx * 13 + 5);
                n_cmp++;
                if (bus.o_data !== exp) begin
                    n_err++;
                    $display("FAIL stream[%0d]: got %h want %h", rx, bus.o_data, exp);
                end
            end else if (seen) gaps++;
            tick();
            if (acc) tx++;
            if (got) rx++;
            cyc++;
        end
        bus.i_valid = 1'b0; bus.i_ready = 1'b0;
        n_cmp++;
        if (rx != 1000 || tx != 1000) begin
            n_err++; $display("FAIL stream_total: rx=%0d tx=%0d want 1000 1000", rx, tx);
        end
        n_cmp++;
        if (gaps != 0 || rdy_drop != 0) begin
            n_err++; $display("FAIL stream_gaps: gaps=%0d ready_drops=%0d want 0 0", gaps, rdy_drop);
        end
        n_cmp++;
        if (cnt_hi != 0) begin
            n_err++; $display("FAIL stream_count: %0d cycles above 3, want 0", cnt_hi);
        end
    endtask

    task automatic test_backpressure_reset();
        int wt;
        int bad = 0;
        logic [15:0] exp;
        bus.i_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.i_valid = 1'b1; bus.i_data = 16'(16'hA000 + k);
            tick();
        end
        bus.i_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (bus.o_valid !== 1'b1 || bus.o_data !== 16'hA000) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL backpressure: %0d unstable cycles, last valid=%b data=%h want 1 a000",
                     bad, bus.o_valid, bus.o_data);
        end
        #3 rst_n = 1'b0;              // mid-cycle, away from any edge
        #1;
        n_cmp++;
        if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: valid=%b ready=%b want 0 0", bus.o_valid, bus.o_ready);
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset: valid=%b ready=%b want 0 1", bus.o_valid, bus.o_ready);
        end
`ifdef FIFO_COUNT_EN
        n_cmp++;
        if (bus.o_count !== 9'd0) begin
            n_err++; $display("FAIL post_reset_count: got %0d want 0", bus.o_count);
        end
`endif
        for (int k = 0; k < 3; k++) begin
            bus.i_valid = 1'b1; bus.i_data = 16'(16'h5A00 + k);
            tick();
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp = 16'(16'h5A00 + k);
            wt = 0;
            while (bus.o_valid !== 1'b1 && wt < 8) begin tick(); wt++; end
            n_cmp++;
            if (bus.o_valid !== 1'b1 || bus.o_data !== exp) begin
                n_err++;
                $display("FAIL post_reset_rd[%0d]: valid=%b data=%h want 1 %h", k, bus.o_valid, bus.o_data, exp);
            end
            tick();
        end
        n_cmp++;
        if (bus.o_valid !== 1'b0) begin
            n_err++; $display("FAIL post_reset_empty: valid=%b want 0", bus.o_valid);
        end
        bus.i_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_fill_full();
        test_back_to_back();
        test_backpressure_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
